// File: rtl/bram_writer_in.sv
// Ping-pong frame writer: streams one frame into a BRAM half, then hands that
// half to the reader with a one-cycle rd_start pulse and switches to the other half.
module bram_writer_in #(
    parameter int width      = 120,
    parameter int height     = 240,
    parameter int frame_size = width * height,
    parameter int addr_bits  = $clog2(frame_size),
    parameter int data_width = 21
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [data_width-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_sof,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic                  wr_bram_index,
    output logic [addr_bits-1:0]  wr_address,
    output logic [data_width-1:0] wr_data,
    output logic                  rd_start,
    output logic                  rd_bram_index,
    input  logic                  rd_idle,
    output logic [7:0]            resync_count
);

    // Handshake: a pixel transfers on a cycle where in_valid && in_ready;
    // in_data/in_sof must be held stable while in_valid is high and in_ready is low.

    typedef enum logic [1:0] {
        ST_WAIT_SOF = 2'd0,
        ST_WRITING  = 2'd1,
        ST_HANDOFF  = 2'd2
    } state_t;

    localparam logic [addr_bits-1:0] LAST_ADDR = addr_bits'(frame_size - 1);
    localparam logic [addr_bits-1:0] ONE       = addr_bits'(1);

    state_t                state_q, state_d;
    logic                  buf_q, buf_d;
    logic [addr_bits-1:0]  count_q, count_d;
    logic [7:0]            resync_q, resync_d;
    logic                  wr_en_q, wr_en_d;
    logic [addr_bits-1:0]  wr_addr_q, wr_addr_d;
    logic [data_width-1:0] wr_data_q, wr_data_d;
    logic                  wr_idx_q, wr_idx_d;
    logic                  rd_start_q, rd_start_d;
    logic                  rd_idx_q, rd_idx_d;
    logic                  accept;
    logic                  do_write;

    assign in_ready = !reset && (state_q != ST_HANDOFF);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        count_d    = count_q;
        resync_d   = resync_q;
        rd_start_d = 1'b0;
        rd_idx_d   = rd_idx_q;
        do_write   = 1'b0;

        case (state_q)
            ST_WAIT_SOF: begin
                if (accept && in_sof) begin
                    do_write = 1'b1;
                    count_d  = ONE;
                    state_d  = ST_WRITING;
                end
            end
            ST_WRITING: begin
                if (accept) begin
                    do_write = 1'b1;
                    if (in_sof) begin
                        // Early SOF restarts the frame in the same buffer.
                        count_d = ONE;
                        if (resync_q != 8'hFF) resync_d = resync_q + 8'd1;
                    end else if (count_q == LAST_ADDR) begin
                        count_d = '0;
                        state_d = ST_HANDOFF;
                    end else begin
                        count_d = count_q + ONE;
                    end
                end
            end
            ST_HANDOFF: begin
                // rd_start is registered, so it lands one cycle after the final
                // write strobe; the state is held through the pulse cycle.
                if (rd_start_q) begin
                    buf_d   = ~buf_q;
                    count_d = '0;
                    state_d = ST_WAIT_SOF;
                end else if (rd_idle) begin
                    rd_start_d = 1'b1;
                    rd_idx_d   = buf_q;
                end
            end
            default: state_d = ST_WAIT_SOF;
        endcase

        wr_en_d   = do_write;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_idx_d  = wr_idx_q;
        if (do_write) begin
            wr_addr_d = in_sof ? '0 : count_q;
            wr_data_d = in_data;
            wr_idx_d  = buf_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_WAIT_SOF;
            buf_q      <= 1'b0;
            count_q    <= '0;
            resync_q   <= 8'd0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_idx_q   <= 1'b0;
            rd_start_q <= 1'b0;
            rd_idx_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            count_q    <= count_d;
            resync_q   <= resync_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_idx_q   <= wr_idx_d;
            rd_start_q <= rd_start_d;
            rd_idx_q   <= rd_idx_d;
        end
    end

    assign wr_en         = wr_en_q;
    assign wr_address    = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign wr_bram_index = wr_idx_q;
    assign rd_start      = rd_start_q;
    assign rd_bram_index = rd_idx_q;
    assign resync_count  = resync_q;

endmodule

// File: tb/tb_bram_writer_in.sv
// Table-driven bench for bram_writer_in with a 4x2 frame: each record holds one
// cycle of inputs and the outputs expected during that same cycle.
module tb_bram_writer_in;

    logic        clk;
    logic        reset;
    logic [20:0] in_data;
    logic        in_valid;
    logic        in_sof;
    logic        in_ready;
    logic        wr_en;
    logic        wr_bram_index;
    logic [2:0]  wr_address;
    logic [20:0] wr_data;
    logic        rd_start;
    logic        rd_bram_index;
    logic        rd_idle;
    logic [7:0]  resync_count;

    bram_writer_in #(.width(4), .height(2), .data_width(21)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_sof(in_sof), .in_ready(in_ready), .wr_en(wr_en),
        .wr_bram_index(wr_bram_index), .wr_address(wr_address), .wr_data(wr_data),
        .rd_start(rd_start), .rd_bram_index(rd_bram_index), .rd_idle(rd_idle),
        .resync_count(resync_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        v;
        logic        sof;
        logic [20:0] d;
        logic        idle;
        logic        e_ready;
        logic        e_we;
        logic [2:0]  e_addr;
        logic [20:0] e_data;
        logic        e_widx;
        logic        e_rs;
        logic        e_ridx;
        logic [7:0]  e_rsc;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] g_rsc;
    int         n_vec;
    int         n_err;

    function automatic void add(input logic rst, input logic v, input logic sof,
                                input logic [20:0] d, input logic idle,
                                input logic e_ready, input logic e_we,
                                input logic [2:0] e_addr, input logic [20:0] e_data,
                                input logic e_widx, input logic e_rs, input logic e_ridx);
        vec_t t;
        t.rst = rst; t.v = v; t.sof = sof; t.d = d; t.idle = idle;
        t.e_ready = e_ready; t.e_we = e_we; t.e_addr = e_addr; t.e_data = e_data;
        t.e_widx = e_widx; t.e_rs = e_rs; t.e_ridx = e_ridx; t.e_rsc = g_rsc;
        vecs.push_back(t);
    endfunction

    // Eight accepted pixels with SOF on the first; each cycle shows the previous write.
    function automatic void add_frame(input logic [20:0] base, input logic b, input logic idle);
        for (int i = 0; i < 8; i++) begin
            logic [20:0] cur;
            logic [20:0] prev;
            cur  = base + 21'(i);
            prev = cur - 21'd1;
            add(1'b0, 1'b1, (i == 0), cur, idle, 1'b1, (i > 0), 3'(i - 1), prev, b, 1'b0, 1'b0);
        end
    endfunction

    // Two handoff cycles: final write, then the rd_start pulse.
    function automatic void add_handoff(input logic [20:0] last, input logic b,
                                        input logic nv, input logic ns, input logic [20:0] nd);
        add(1'b0, nv, ns, nd, 1'b1, 1'b0, 1'b1, 3'd7, last, b, 1'b0, 1'b0);
        add(1'b0, nv, ns, nd, 1'b1, 1'b0, 1'b0, 3'd0, 21'd0, 1'b0, 1'b1, b);
    endfunction

    function automatic void idle_cycle(input logic idle, input logic e_ready);
        add(1'b0, 1'b0, 1'b0, 21'd0, idle, e_ready, 1'b0, 3'd0, 21'd0, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic cmp(input string name, input int n, input logic [31:0] got, input logic [31:0] exp);
        if (got !== exp) begin
            n_err++;
            $display("FAIL vec%0d %s: got 0x%0h, expected 0x%0h", n, name, got, exp);
        end
    endtask

    task automatic check(input vec_t t, input int n);
        cmp("in_ready", n, 32'(in_ready), 32'(t.e_ready));
        cmp("wr_en", n, 32'(wr_en), 32'(t.e_we));
        if (t.e_we || t.rst) begin
            cmp("wr_address", n, 32'(wr_address), 32'(t.e_addr));
            cmp("wr_data", n, 32'(wr_data), 32'(t.e_data));
            cmp("wr_bram_index", n, 32'(wr_bram_index), 32'(t.e_widx));
        end
        cmp("rd_start", n, 32'(rd_start), 32'(t.e_rs));
        if (t.e_rs || t.rst)
            cmp("rd_bram_index", n, 32'(rd_bram_index), 32'(t.e_ridx));
        cmp("resync_count", n, 32'(resync_count), 32'(t.e_rsc));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        g_rsc = 8'd0;
        reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = 21'd0; rd_idle = 1'b1;

        // Reset, then in_sof without in_valid must be ignored; first frame into buffer 0.
        add(1'b1, 1'b0, 1'b0, 21'd0, 1'b1, 1'b0, 1'b0, 3'd0, 21'd0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 21'h99, 1'b1, 1'b1, 1'b0, 3'd0, 21'd0, 1'b0, 1'b0, 1'b0);
        idle_cycle(1'b1, 1'b1);
        add_frame(21'h10, 1'b0, 1'b1);
        add_handoff(21'h17, 1'b0, 1'b0, 1'b0, 21'd0);

        // Three pixels before any SOF are consumed without writes; frame goes to buffer 1.
        for (int i = 0; i < 3; i++)
            add(1'b0, 1'b1, 1'b0, 21'hA0 + 21'(i), 1'b1, 1'b1, 1'b0, 3'd0, 21'd0, 1'b0, 1'b0, 1'b0);
        add_frame(21'h20, 1'b1, 1'b1);
        add_handoff(21'h27, 1'b1, 1'b0, 1'b0, 21'd0);

        // Early SOF on the 5th pixel restarts at address 0 in buffer 0.
        for (int k = 0; k < 12; k++) begin
            int paddr;
            if (k == 5) g_rsc = 8'd1;
            paddr = ((k - 1) < 4) ? (k - 1) : (k - 5);
            add(1'b0, 1'b1, (k == 0 || k == 4), 21'h30 + 21'(k), 1'b1, 1'b1, (k > 0),
                3'(paddr), 21'h30 + 21'(k) - 21'd1, 1'b0, 1'b0, 1'b0);
        end
        add_handoff(21'h3B, 1'b0, 1'b0, 1'b0, 21'd0);

        // Reader busy at frame end: backpressure until rd_idle rises 10 cycles later.
        add_frame(21'h40, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b1, 21'h50, 1'b0, 1'b0, 1'b1, 3'd7, 21'h47, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++)
            add(1'b0, 1'b1, 1'b1, 21'h50, 1'b0, 1'b0, 1'b0, 3'd0, 21'd0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 21'h50, 1'b1, 1'b0, 1'b0, 3'd0, 21'd0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 21'h50, 1'b1, 1'b0, 1'b0, 3'd0, 21'd0, 1'b0, 1'b1, 1'b1);

        // Continuous valid stream, three back-to-back frames: buffers 0, 1, 0.
        for (int f = 0; f < 3; f++) begin
            logic [20:0] base;
            base = 21'h50 + 21'(16 * f);
            add_frame(base, 1'(f % 2), 1'b1);
            if (f < 2) add_handoff(base + 21'd7, 1'(f % 2), 1'b1, 1'b1, base + 21'd16);
            else       add_handoff(base + 21'd7, 1'(f % 2), 1'b0, 1'b0, 21'd0);
        end

        // Reset after 5 pixels of a buffer-1 frame: outputs clear, next frame in buffer 0.
        for (int i = 0; i < 5; i++)
            add(1'b0, 1'b1, (i == 0), 21'h60 + 21'(i), 1'b1, 1'b1, (i > 0), 3'(i - 1),
                21'h60 + 21'(i) - 21'd1, 1'b1, 1'b0, 1'b0);
        g_rsc = 8'd0;
        add(1'b1, 1'b0, 1'b0, 21'd0, 1'b1, 1'b0, 1'b0, 3'd0, 21'd0, 1'b0, 1'b0, 1'b0);
        idle_cycle(1'b1, 1'b1);
        add_frame(21'h70, 1'b0, 1'b1);
        add_handoff(21'h77, 1'b0, 1'b0, 1'b0, 21'd0);
        idle_cycle(1'b1, 1'b1);

        foreach (vecs[n]) begin
            if (n > 0) @(posedge clk);
            #1;
            reset    = vecs[n].rst;
            in_valid = vecs[n].v;
            in_sof   = vecs[n].sof;
            in_data  = vecs[n].d;
            rd_idle  = vecs[n].idle;
            @(negedge clk);
            check(vecs[n], n);
            n_vec++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
